fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage feeding the decode/control path of the reduced RISC-V core. Owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid handshake. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
ADDRESS_WIDTH, 32, PC and imem address width
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
redirect  input  1  taken branch/jump this cycle
redirect_PC  input  ADDRESS_WIDTH  redirect target
imem_req  output  1  read request
imem_addr  output  ADDRESS_WIDTH  read address (word aligned)
imem_gnt  input  1  request accepted when imem_req&&imem_gnt
imem_rvalid  input  1  read data valid; in order, >=1 cycle after grant
imem_rdata  input  DATA_WIDTH  read data
instr_valid  output  1  instr/instr_PC hold a valid entry
instr_ready  input  1  decode accepts; transfer on valid&&ready
instr  output  DATA_WIDTH  instruction word
instr_PC  output  ADDRESS_WIDTH  PC of instr

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst low on a rising edge resets).
- Reset: fetch_PC=RESET_PC, FIFO empty, outstanding=0, discard=0; imem_req=0 and instr_valid=0 while rst low.
- Credit: imem_req=1 iff out of reset, !redirect, and (FIFO count + outstanding) < FIFO_DEPTH. imem_addr=fetch_PC.
- Grant: fetch_PC += 4 (wraps mod 2^ADDRESS_WIDTH); outstanding +=1. The issued PC is pushed into a PC-tag queue of depth FIFO_DEPTH.
- Response: on imem_rvalid, pop PC tag and decrement outstanding. If discard>0, drop the word and decrement discard. Otherwise push {imem_rdata, tag} into the FIFO. A grant and a response in the same cycle leave outstanding unchanged.
- Output: instr/instr_PC = FIFO head, instr_valid = !empty. Combinational from registered state; no bypass from imem_rdata. Minimum latency: grant at cycle N, rvalid at N+1, instr_valid at N+2.
- Pop on instr_valid&&instr_ready. Push and pop in the same cycle are allowed when full, because credit guarantees no overflow.
- Overflow and underflow are impossible by construction. An assertion flags a push when full or an rvalid with outstanding==0.
- Redirect (highest priority after reset):
  - fetch_PC <= redirect_PC; FIFO and PC-tag queue are flushed; instr_valid=0 the next cycle.
  - discard <= outstanding adjusted for same-cycle rvalid, so every response already in flight is dropped.
  - imem_req is forced 0 in the redirect cycle, so no grant is lost to the old path.
  - Fetch resumes at redirect_PC the following cycle.
- Redirect while discard>0: the discard count accumulates correctly (the new value of outstanding).
- redirect_PC[1:0]!=0 is ignored: bits [1:0] are forced to 0.
- imem_req stays asserted until granted, with imem_addr held stable (no retraction).

Optional Feature:
FETCH_STATS_EN: when defined, adds outputs stat_fetched (32b, count of instructions delivered to decode) and stat_flushed (32b, count of entries and responses discarded by redirect). Both reset to 0 and saturate at all-ones. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle rvalid, instr_ready=1 -> imem_addr 0,4,8,...; first instr_valid 2 cycles after first grant; instr_PC=0,4,8 back-to-back.
- instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 grants; imem_req drops to 0; instr_valid held with instr_PC=0 stable; resumes on ready.
- imem_gnt low for 3 cycles with imem_req=1 -> imem_addr held at 0x0 throughout; PC advances only after grant.
- Redirect to 0x100 with 2 responses outstanding -> both responses dropped; instr_valid=0 the next cycle; next delivered instr_PC=0x100.
- Redirect in the same cycle as rvalid and pop -> no stale word delivered; discard count correct; next instr_PC=redirect_PC.
- rst low mid-stream with FIFO full -> next cycle instr_valid=0, imem_req=0; after release fetch restarts at RESET_PC; with FETCH_STATS_EN both stats read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/gnt/rvalid fetcher, instruction FIFO to decode, redirect flush.
// Define FETCH_STATS_EN to add saturating stat_fetched/stat_flushed counters.
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_PC,
  output logic imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic imem_gnt,
  input  logic imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDRESS_WIDTH-1:0] instr_PC
`ifdef FETCH_STATS_EN
  , output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] tag_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q, tag_wr_q, tag_rd_q;
  logic [CW-1:0] count_q, out_q, disc_q;
  logic grant, drop, push, pop;
  // Credit counts buffered words plus every in-flight response, stale ones included.
  assign imem_req = rst && !redirect && ({1'b0, count_q} + {1'b0, out_q} < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign instr_valid = rst && count_q != '0;
  assign instr = fifo_data_q[rd_q];
  assign instr_PC = fifo_pc_q[rd_q];
  assign grant = imem_req && imem_gnt;
  assign drop = imem_rvalid && (redirect || disc_q != '0);
  assign push = imem_rvalid && !drop;
  assign pop = instr_valid && instr_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      out_q <= '0;
      disc_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      out_q <= out_q + CW'(grant) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc_q <= redirect_PC & ~ADDRESS_WIDTH'(3);
        disc_q <= out_q - CW'(imem_rvalid);
        count_q <= '0;
        rd_q <= wr_q;
        tag_rd_q <= tag_wr_q;
      end else begin
        if (grant) fetch_pc_q <= fetch_pc_q + ADDRESS_WIDTH'(4);
        if (grant) tag_wr_q <= tag_wr_q + PW'(1);
        if (drop) disc_q <= disc_q - CW'(1);
        if (push) wr_q <= wr_q + PW'(1);
        if (push) tag_rd_q <= tag_rd_q + PW'(1);
        if (pop) rd_q <= rd_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
  // Tags only track live requests; dropped responses never consume one.
  always_ff @(posedge clk) begin
    if (push) fifo_data_q[wr_q] <= imem_rdata;
    if (push) fifo_pc_q[wr_q] <= tag_q[tag_rd_q];
    if (grant) tag_q[tag_wr_q] <= fetch_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && !pop && count_q == CW'(FIFO_DEPTH)));
      assert (!(imem_rvalid && out_q == '0));
    end
  end
`ifdef FETCH_STATS_EN
  logic [31:0] fl_inc;
  logic [32:0] fetched_sum, flushed_sum;
  assign fl_inc = (redirect ? 32'(count_q - CW'(pop)) : 32'd0) + 32'(drop);
  assign fetched_sum = {1'b0, stat_fetched} + 33'(pop);
  assign flushed_sum = {1'b0, stat_flushed} + {1'b0, fl_inc};
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle table plus randomized run against a queue-based fetch model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst, redirect, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
  logic [31:0] redirect_PC, imem_addr, imem_rdata, instr, instr_PC;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif
  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_PC(redirect_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_PC(instr_PC)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rs, rd;
    logic [31:0] rpc;
    logic g, rv;
    logic [31:0] ra;
    logic rdy, req;
    logic [31:0] ad;
    logic vl;
    logic [31:0] ip;
  } vec_t;

  typedef struct { logic [31:0] a; bit stale; } fl_t;
  typedef struct { logic [31:0] pc, d; } ent_t;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_1357;
  endfunction

  function automatic vec_t v(input logic rs, rd, input logic [31:0] rpc, input logic g, rv,
                             input logic [31:0] ra, input logic rdy, req, input logic [31:0] ad,
                             input logic vl, input logic [31:0] ip);
    vec_t t;
    t.rs = rs; t.rd = rd; t.rpc = rpc; t.g = g; t.rv = rv; t.ra = ra; t.rdy = rdy;
    t.req = req; t.ad = ad; t.vl = vl; t.ip = ip;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  vec_t tbl[$];
  fl_t infl[$];
  ent_t fq[$];
  logic [31:0] mpc;

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_PC = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    //               rs rd rpc      g rv ra       rdy| req ad       vl ip
    tbl.push_back(v(0, 0, 0,       1, 0, 0,       0,   0, 0,       0, 0));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   1, 0,       0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 0,       1,   1, 4,       0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 4,       1,   0, 8,       1, 0));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   1, 8,       1, 4));
    tbl.push_back(v(1, 0, 0,       1, 1, 8,       1,   1, 12,      0, 0));
    // decode stalls: FIFO fills, credit runs out, head held stable
    tbl.push_back(v(1, 0, 0,       1, 1, 12,      0,   0, 16,      1, 8));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       0,   0, 16,      1, 8));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       0,   0, 16,      1, 8));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   0, 16,      1, 8));
    // grant withheld for 3 cycles: address held
    tbl.push_back(v(1, 0, 0,       0, 0, 0,       1,   1, 16,      1, 12));
    tbl.push_back(v(1, 0, 0,       0, 0, 0,       1,   1, 16,      0, 0));
    tbl.push_back(v(1, 0, 0,       0, 0, 0,       1,   1, 16,      0, 0));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   1, 16,      0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 16,      1,   1, 20,      0, 0));
    tbl.push_back(v(1, 0, 0,       0, 1, 20,      1,   0, 24,      1, 16));
    tbl.push_back(v(1, 0, 0,       0, 0, 0,       0,   1, 24,      1, 20));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       0,   1, 24,      1, 20));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   0, 28,      1, 20));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   1, 28,      0, 0));
    // redirect (misaligned target) with two responses in flight
    tbl.push_back(v(1, 1, 'h102,   1, 0, 0,       1,   0, 32,      0, 0));
    tbl.push_back(v(1, 0, 0,       0, 1, 24,      1,   0, 'h100,   0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 28,      1,   1, 'h100,   0, 0));
    tbl.push_back(v(1, 0, 0,       0, 1, 'h100,   0,   1, 'h104,   0, 0));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       0,   1, 'h104,   1, 'h100));
    // redirect together with rvalid and pop
    tbl.push_back(v(1, 1, 'h200,   1, 1, 'h104,   1,   0, 'h108,   1, 'h100));
    tbl.push_back(v(1, 0, 0,       1, 0, 0,       1,   1, 'h200,   0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 'h200,   0,   1, 'h204,   0, 0));
    tbl.push_back(v(1, 0, 0,       1, 1, 'h204,   0,   0, 'h208,   1, 'h200));
    // reset with FIFO full
    tbl.push_back(v(0, 0, 0,       1, 0, 0,       0,   0, 'h208,   0, 0));
    tbl.push_back(v(1, 0, 0,       0, 0, 0,       1,   1, 0,       0, 0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rs; redirect = tbl[i].rd; redirect_PC = tbl[i].rpc; imem_gnt = tbl[i].g;
      imem_rvalid = tbl[i].rv; imem_rdata = memf(tbl[i].ra); instr_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d req", i), imem_req, tbl[i].req);
      chk($sformatf("row%0d addr", i), imem_addr, tbl[i].ad);
      chk($sformatf("row%0d valid", i), instr_valid, tbl[i].vl);
      if (tbl[i].vl) begin
        chk($sformatf("row%0d instr_PC", i), instr_PC, tbl[i].ip);
        chk($sformatf("row%0d instr", i), instr, memf(tbl[i].ip));
      end
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetched after reset", stat_fetched, 32'h0);
    chk("stat_flushed after reset", stat_flushed, 32'h0);
`endif

    mpc = '0;
    for (int i = 0; i < 4000; i++) begin
      logic e_req, e_vld, g;
      fl_t f;
      @(negedge clk);
      rst = !(i < 2 || $urandom_range(0, 79) == 0);
      redirect = rst && $urandom_range(0, 9) == 0;
      redirect_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
      imem_gnt = $urandom_range(0, 3) != 0;
      imem_rvalid = rst && infl.size() > 0 && $urandom_range(0, 2) != 0;
      imem_rdata = infl.size() > 0 ? memf(infl[0].a) : $urandom;
      instr_ready = $urandom_range(0, 3) != 0;
      #1;
      e_req = rst && !redirect && (fq.size() + infl.size() < DEPTH);
      e_vld = rst && fq.size() > 0;
      if (i >= 2) begin
        chk("rand req", imem_req, e_req);
        chk("rand addr", imem_addr, mpc);
        chk("rand valid", instr_valid, e_vld);
        if (e_vld) begin
          chk("rand instr_PC", instr_PC, fq[0].pc);
          chk("rand instr", instr, fq[0].d);
        end
      end
      if (!rst) begin
        mpc = '0;
        fq.delete();
        infl.delete();
      end else begin
        g = e_req && imem_gnt;
        if (imem_rvalid) f = infl.pop_front();
        if (redirect) begin
          fq.delete();
          foreach (infl[k]) infl[k].stale = 1'b1;
          mpc = {redirect_PC[31:2], 2'b00};
        end else begin
          if (e_vld && instr_ready) void'(fq.pop_front());
          if (imem_rvalid && !f.stale) fq.push_back('{f.a, memf(f.a)});
          if (g) begin
            infl.push_back('{mpc, 1'b0});
            mpc = mpc + 32'd4;
          end
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
